// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave to APB master, single clock (Hclk).
// Each accepted AHB beat becomes one APB SETUP/ACCESS transfer. The AHB
// data phase is stretched (HREADYOUT=0) until the APB transfer completes.
//
// Ports:
//   Hclk, Hresetn (sync, active-low)
//   AHB in : HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, HBURST (unused)
//   AHB out: HREADYOUT, HRDATA, HRESP
//   APB out: PSEL, PENABLE, PADDR, PWRITE, PWDATA
//   APB in : PRDATA, PREADY, PSLVERR
//
// Optional feature: define AHB2APB_PSLVERR_EN to map PSLVERR onto a
// two-cycle AHB ERROR response. Without it PSLVERR is ignored and HRESP=0.
module ahb_apb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [1:0]        HBURST,
  output logic              HREADYOUT,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HRESP,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;

  logic accept, slv_err;

  // HTRANS[1] covers NONSEQ and SEQ; IDLE/BUSY fall out.
  assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB2APB_PSLVERR_EN
  assign slv_err = PSLVERR;
  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0]};
`else
  assign slv_err = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0], PSLVERR};
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          state_d  = HWRITE ? S_WWAIT : S_SETUP;
        end
      end
      S_WWAIT: begin
        // HWDATA is valid in the data phase, one cycle after the accept.
        pwdata_d = HWDATA;
        state_d  = S_SETUP;
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          if (!pwrite_q) hrdata_d = PRDATA;
          state_d = slv_err ? S_ERR1 : S_IDLE;
        end
      end
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    hreadyout_d = (state_d == S_IDLE) || (state_d == S_ERR2);
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
